qsys_pipeline_sink: RTL and testbench
=====================================

# qsys_pipeline_sink

- Receiving end of a latency-insensitive valid/ready link whose forward (data/valid) and backward (ready) paths are both pipelined through `PIPE_STAGES` register stages.
- Owns a small FIFO and a ready-history credit scheme, so every beat launched against an already-delayed ready is absorbed without loss.
- Presents a plain zero-latency valid/ready interface to the downstream pearl.
- Sits at the consumer side of every pipelined Qsys channel in the shell.

## Interface
Parameters:
- `DATA_WIDTH`, 32: payload bits.
- `PIPE_STAGES`, 2: register stages on each direction of the link; must be ≥1.
- `DEPTH`, 6: FIFO entries.
  - Must be ≥1; elaboration error otherwise.
  - Full throughput requires ≥2*PIPE_STAGES+1.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `i_data`  in  DATA_WIDTH  beat from link pipeline.
- `i_valid`  in  1  beat present on `i_data`.
- `o_ready`  out  1  credit to link; enters upstream pipeline.
- `o_data`  out  DATA_WIDTH  FIFO head to pearl.
- `o_valid`  out  1  FIFO non-empty.
- `i_ready`  in  1  pearl accepts head.
- `o_count`  out  $clog2(DEPTH+1)  current occupancy.
- `o_proto_err`  out  1  sticky: beat arrived without a matching credit.

## Operation
- Round trip `RT = 2*PIPE_STAGES`. A beat arriving in cycle t is legal only if `o_ready` was 1 in cycle t−RT.
- `hist[RT-1:0]` is a shift register of past `o_ready`. `hist[0]` is last cycle; `hist[RT-1]` is RT cycles ago.
- `o_ready = (count + popcount(hist)) < DEPTH`. It is combinational from registers only; no path from `i_valid` or `i_ready`.
- Invariant: `count + popcount(hist) ≤ DEPTH`, so the FIFO never overflows under a legal source.
- Push when `i_valid && hist[RT-1]`: write `i_data` at `wr_ptr`.
- Illegal arrival (`i_valid && !hist[RT-1]`): beat dropped, `o_proto_err` set, held until reset.
- Pop when `o_valid && i_ready`.
- `o_valid = (count != 0)`; `o_data = mem[rd_ptr]` (show-ahead).
- Pointers wrap DEPTH−1 → 0; DEPTH need not be a power of two.
- Simultaneous push and pop: count unchanged, both pointers advance; legal at any occupancy including full and empty-with-push.
- Push and pop never address the same entry in one cycle, except push into empty, where the data is visible next cycle.

## Timing
- Reset values:
  - `count=0`, pointers 0, `hist=0`.
  - `o_valid=0`, `o_proto_err=0`, `o_count=0`.
  - `o_ready=1` once reset deasserts, since 0+0<DEPTH.
  - `o_data`: don't-care while `o_valid=0`.
- Latency: beat accepted on edge k → `o_valid=1` and `o_data` valid after edge k (the cycle after arrival).
- Source-to-pearl latency = PIPE_STAGES+1.
- Credit turnaround: a pop at edge k raises `o_ready` no earlier than after edge k.
- Steady-state throughput is 1 beat/cycle iff DEPTH ≥ RT+1 and the pearl holds `i_ready=1`.
- Reset mid-operation:
  - FIFO contents and history are discarded immediately.
  - Upstream pipeline registers have no reset, so the shell flushes the link for RT cycles around reset.
  - Any beat arriving in that window without a post-reset credit is flagged by `o_proto_err`.
- `o_proto_err` rises the cycle after the offending arrival.

## Structure
- Shared package `qsys_li_pkg`:
  - `function min_sink_depth(stages)` returning 2*stages+1.
  - Width helper `cnt_w(depth)=$clog2(depth+1)`.
- Sub-module `qsys_li_fifo_mem`: DEPTH×DATA_WIDTH register array with one write port and one async read port; pointers stay in the parent.
- Parent holds `hist`, the popcount, `count`, the pointers and the error flag.

## Test plan
- Reset then idle, PIPE_STAGES=2, DEPTH=6 → `o_ready=1`, `o_valid=0`, `o_count=0`, `o_proto_err=0`.
- Legal model source (honours delayed ready) streams 0x1..0x40 with `i_ready=1` → `o_data` sequence 0x1..0x40 in order, gap-free after fill, `o_count ≤ 1`.
- Same stream with `i_ready=0` for 20 cycles, then 1 → `o_count` peaks at exactly 6, `o_ready` falls within 1 cycle of credits exhausted, no loss, order preserved, `o_proto_err=0`.
- Random `i_ready` (50%), 1000 beats, DEPTH=5 with pointer wrap → scoreboard exact match, `count + popcount(hist) ≤ DEPTH` asserted every cycle.
- Force `i_valid=1` for 0xDEAD on the first cycle after reset (no credit) → beat not stored, `o_proto_err=1` next cycle and sticky, `o_count=0`.
- Assert `reset` with 4 entries stored → `o_valid=0` and `o_count=0` immediately (async), `o_ready=1` after release, no stale data emitted.

Source files
------------

// File: rtl/qsys_li_pkg.sv
// qsys_li_pkg
//   Shared helpers for the latency-insensitive Qsys channel blocks.
//   min_sink_depth(stages) : smallest sink FIFO depth that sustains one beat
//                            per cycle across a link with `stages` register
//                            stages in each direction.
//   cnt_w(depth)           : width of an occupancy counter that can hold
//                            0..depth inclusive.
package qsys_li_pkg;

  function automatic int min_sink_depth(input int stages);
    return 2 * stages + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/qsys_pipeline_sink_if.sv
// qsys_pipeline_sink_if
//   One valid/ready channel: data, valid, ready.
//   Handshake: the master drives data/valid, the slave drives ready. A beat
//   transfers on a rising clock edge where valid and ready are both 1. On the
//   pipelined link side of the sink, ready is a credit that reaches the
//   source several cycles late. The source decides on that delayed view, so
//   valid may be seen without ready in the same cycle. On the pearl side the
//   handshake is the plain zero-latency form.
//   Modports:
//     master : output data, valid; input ready
//     slave  : input data, valid; output ready
interface qsys_pipeline_sink_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/qsys_li_fifo_mem.sv
// qsys_li_fifo_mem
//   DEPTH x DATA_WIDTH register array with one synchronous write port and one
//   asynchronous (show-ahead) read port. The pointers are owned by the parent.
//   Ports:
//     clock : write clock
//     we    : write enable
//     waddr : write index, must be < DEPTH when we=1
//     wdata : write data
//     raddr : read index
//     rdata : mem[raddr], combinational
module qsys_li_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter int AW         = 3
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Payload storage carries no reset; its contents only matter while the
  // parent reports the entry as occupied.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qsys_pipeline_sink.sv
// qsys_pipeline_sink
//   Consumer end of a latency-insensitive link. The forward (data/valid) path
//   and the backward (ready) path each pass through PIPE_STAGES register
//   stages. A beat that arrives now was launched against the ready value of
//   RT = 2*PIPE_STAGES cycles ago. The block remembers those RT ready values
//   in `hist`. It only grants a new credit when the FIFO has room for every
//   beat that may still be in flight.
//   Ports:
//     clock, reset : clock, asynchronous active-high reset
//     link         : slave side of the pipelined link (data/valid in, ready out)
//     pearl        : master side towards the pearl (show-ahead FIFO head)
//     o_count      : current FIFO occupancy
//     o_proto_err  : sticky flag, set when a beat arrives without a credit
//   The interface instances must be built with DATA_WIDTH matching this block.
module qsys_pipeline_sink
  import qsys_li_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter int DEPTH       = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  qsys_pipeline_sink_if.slave      link,
  qsys_pipeline_sink_if.master     pearl,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_proto_err
);

  localparam int RT = 2 * PIPE_STAGES;
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for count + popcount(hist) even if the bound were violated.
  localparam int OW = $clog2(DEPTH + RT + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("qsys_pipeline_sink: DEPTH must be >= 1");
  end
  if (PIPE_STAGES < 1) begin : g_bad_stages
    $error("qsys_pipeline_sink: PIPE_STAGES must be >= 1");
  end

  logic [RT-1:0] hist;        // hist[0] = ready last cycle, hist[RT-1] = RT ago
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          proto_err;

  logic [OW-1:0] hist_pop;
  logic [OW-1:0] outstanding;
  logic          credit_ok;
  logic          push;
  logic          pop;
  logic          bad_arrival;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // DEPTH need not be a power of two, so wrap explicitly.
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Each set bit in hist is a credit already granted whose beat may still be
  // in flight.
  always_comb begin
    hist_pop = '0;
    for (int i = 0; i < RT; i++) begin
      hist_pop = hist_pop + OW'(hist[i]);
    end
  end

  assign outstanding = OW'(count) + hist_pop;
  // Driven only from registers; the link's ready loop stays free of
  // combinational paths from i_valid / i_ready.
  assign credit_ok   = outstanding < OW'(DEPTH);

  // A beat is legal only if the credit it was launched against is the one now
  // leaving the history.
  assign push        = link.valid &&  hist[RT-1];
  assign bad_arrival = link.valid && !hist[RT-1];

  assign pearl.valid = (count != '0);
  assign pop         = pearl.valid && pearl.ready;

  assign link.ready  = credit_ok;
  assign o_count     = count;
  assign o_proto_err = proto_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      hist <= {hist[RT-2:0], credit_ok};
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bad_arrival) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Push into an empty FIFO writes the entry rd_ptr points at, but pop is
  // impossible while empty, so the new head shows up on rdata next cycle.
  qsys_li_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (link.data),
    .raddr (rd_ptr),
    .rdata (pearl.data)
  );

endmodule

// File: tb/tb_qsys_pipeline_sink.sv
// tb_qsys_pipeline_sink
//   Two sinks (DEPTH=6 and DEPTH=5, PIPE_STAGES=2) behind a model of the
//   pipelined link: a source that sees ready PS cycles late and whose beats
//   reach the sink PS cycles after launch.
module tb_qsys_pipeline_sink;
  localparam int W  = 32;
  localparam int PS = 2;
  localparam int RT = 2 * PS;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  qsys_pipeline_sink_if #(.DATA_WIDTH(W)) link6  ();
  qsys_pipeline_sink_if #(.DATA_WIDTH(W)) pearl6 ();
  qsys_pipeline_sink_if #(.DATA_WIDTH(W)) link5  ();
  qsys_pipeline_sink_if #(.DATA_WIDTH(W)) pearl5 ();
  logic [2:0] count6, count5;
  logic       err6, err5;

  logic         sel = 1'b0;       // 0: DEPTH=6 sink, 1: DEPTH=5 sink
  logic         drv_valid = 1'b0;
  logic [W-1:0] drv_data  = '0;
  logic         drv_ready = 1'b0;

  assign link6.valid  = (sel == 1'b0) ? drv_valid : 1'b0;
  assign link6.data   = drv_data;
  assign pearl6.ready = (sel == 1'b0) ? drv_ready : 1'b0;
  assign link5.valid  = (sel == 1'b1) ? drv_valid : 1'b0;
  assign link5.data   = drv_data;
  assign pearl5.ready = (sel == 1'b1) ? drv_ready : 1'b0;

  logic         cur_ready, cur_valid, cur_err;
  logic [W-1:0] cur_data;
  logic [2:0]   cur_count;
  assign cur_ready = sel ? link5.ready : link6.ready;
  assign cur_valid = sel ? pearl5.valid : pearl6.valid;
  assign cur_data  = sel ? pearl5.data : pearl6.data;
  assign cur_count = sel ? count5 : count6;
  assign cur_err   = sel ? err5 : err6;

  qsys_pipeline_sink #(.DATA_WIDTH(W), .PIPE_STAGES(PS), .DEPTH(6)) u_dut6 (
    .clock       (clock),
    .reset       (rst),
    .link        (link6),
    .pearl       (pearl6),
    .o_count     (count6),
    .o_proto_err (err6)
  );

  qsys_pipeline_sink #(.DATA_WIDTH(W), .PIPE_STAGES(PS), .DEPTH(5)) u_dut5 (
    .clock       (clock),
    .reset       (rst),
    .link        (link5),
    .pearl       (pearl5),
    .o_count     (count5),
    .o_proto_err (err5)
  );

  // ---------------- scoreboard / checker ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // ---------------- link model ----------------
  bit           rh[RT];     // rh[i] = o_ready i+1 cycles ago
  bit           v_sr[PS];
  logic [W-1:0] d_sr[PS];
  int next_beat, last_beat, got, peak, rdy_stall, first_pop, last_pop, cnt_rel;
  bit rdy_rel;

  task automatic model_clear();
    for (int i = 0; i < RT; i++) rh[i] = 1'b0;
    for (int i = 0; i < PS; i++) begin
      v_sr[i] = 1'b0;
      d_sr[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    drv_data  = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
  endtask

  // Called once per cycle, 1 time unit after the rising edge, drv_ready set.
  task automatic link_cycle(input int c);
    int pop_n;
    int depth;
    bit launch;
    logic [W-1:0] e;
    depth = sel ? 5 : 6;
    pop_n = 0;
    for (int i = 0; i < RT; i++) pop_n += int'(rh[i]);
    check("credit_inv", 32'((int'(cur_count) + pop_n) <= depth), 32'd1);
    if (int'(cur_count) > peak) peak = int'(cur_count);
    if (cur_valid && drv_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_empty_pop", 32'(cur_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", cur_data, e);
      end
      got++;
      if (first_pop < 0) first_pop = c;
      last_pop = c;
    end
    drv_valid = v_sr[PS-1];
    drv_data  = d_sr[PS-1];
    if (v_sr[PS-1]) exp_q.push_back(d_sr[PS-1]);
    launch = rh[PS-1] && (next_beat <= last_beat);
    for (int i = PS - 1; i > 0; i--) begin
      v_sr[i] = v_sr[i-1];
      d_sr[i] = d_sr[i-1];
    end
    v_sr[0] = launch;
    d_sr[0] = launch ? W'(next_beat) : '0;
    if (launch) next_beat++;
    for (int i = RT - 1; i > 0; i--) rh[i] = rh[i-1];
    rh[0] = cur_ready;
  endtask

  // Streams beats 1..n. Pearl ready: random, or 0 for `stall` cycles then 1.
  task automatic run_stream(input int n, input int stall, input bit rnd, input int budget);
    next_beat = 1; last_beat = n; got = 0; peak = 0; rdy_stall = 0;
    first_pop = -1; last_pop = -1; cnt_rel = -1; rdy_rel = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (got >= n && c >= stall) break;
      if (rnd) drv_ready = 1'($urandom_range(0, 1));
      else     drv_ready = (c >= stall);
      if (c == stall) begin
        cnt_rel = int'(cur_count);
        rdy_rel = cur_ready;
      end
      if (c < stall && cur_ready) rdy_stall++;
      link_cycle(c);
      @(posedge clock);
      #1;
    end
    drv_valid = 1'b0;
    drv_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    // Reset then idle
    do_reset();
    check("t1_ready", 32'(cur_ready), 32'd1);
    check("t1_valid", 32'(cur_valid), 32'd0);
    check("t1_count", 32'(cur_count), 32'd0);
    check("t1_err",   32'(cur_err),   32'd0);

    // Legal stream, pearl always ready
    run_stream(64, 0, 1'b0, 400);
    check("t2_got",   32'(got), 32'd64);
    check("t2_first", 32'(first_pop), 32'd5);
    check("t2_gapless", 32'(last_pop - first_pop), 32'd63);
    check("t2_peak",  32'(peak), 32'd1);
    check("t2_left",  32'(exp_q.size()), 32'd0);
    check("t2_err",   32'(cur_err), 32'd0);

    // Pearl stalls 20 cycles: credits run out at exactly DEPTH
    do_reset();
    run_stream(64, 20, 1'b0, 600);
    check("t3_got",       32'(got), 32'd64);
    check("t3_peak",      32'(peak), 32'd6);
    check("t3_rdy_grants", 32'(rdy_stall), 32'd6);
    check("t3_cnt_full",  32'(cnt_rel), 32'd6);
    check("t3_rdy_full",  32'(rdy_rel), 32'd0);
    check("t3_left",      32'(exp_q.size()), 32'd0);
    check("t3_err",       32'(cur_err), 32'd0);

    // Beat without credit right after reset
    do_reset();
    drv_valid = 1'b1;
    drv_data  = 32'hDEAD;
    check("t5_err_pre", 32'(cur_err), 32'd0);
    @(posedge clock);
    #1;
    drv_valid = 1'b0;
    check("t5_err",   32'(cur_err),   32'd1);
    check("t5_count", 32'(cur_count), 32'd0);
    check("t5_valid", 32'(cur_valid), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    check("t5_sticky", 32'(cur_err), 32'd1);
    check("t5_count_late", 32'(cur_count), 32'd0);

    // Asynchronous reset with 4 entries stored
    do_reset();
    run_stream(4, 1000, 1'b0, 15);
    check("t6_count4", 32'(cur_count), 32'd4);
    #3 rst = 1'b1;
    #1;
    check("t6_valid_async", 32'(cur_valid), 32'd0);
    check("t6_count_async", 32'(cur_count), 32'd0);
    @(posedge clock);
    #1 rst = 1'b0;
    check("t6_ready", 32'(cur_ready), 32'd1);
    check("t6_err",   32'(cur_err),   32'd0);
    model_clear();
    next_beat = 1; last_beat = 0; got = 0; first_pop = -1;
    for (int c = 0; c < 10; c++) begin
      drv_ready = 1'b1;
      link_cycle(c);
      @(posedge clock);
      #1;
    end
    drv_ready = 1'b0;
    check("t6_no_stale", 32'(got), 32'd0);
    check("t6_valid_end", 32'(cur_valid), 32'd0);

    // DEPTH=5, random pearl ready, 1000 beats
    sel = 1'b1;
    do_reset();
    run_stream(1000, 0, 1'b1, 20000);
    check("t4_got",  32'(got), 32'd1000);
    check("t4_left", 32'(exp_q.size()), 32'd0);
    check("t4_peak_le", 32'(peak <= 5), 32'd1);
    check("t4_err",  32'(cur_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
